// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin packet arbiter.
// Defines the arbiter state encoding, the select-width helper and the round-robin search.
package axis_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Upper bound on the number of requesters that next_rr can search.
    localparam int MAX_N = 32;

    function automatic int sel_width(input int n);
        return ($clog2(n) > 0) ? $clog2(n) : 1;
    endfunction

    // First requester at or after ptr, wrapping modulo n; returns ptr when nobody requests.
    function automatic int next_rr(input int ptr, input logic [MAX_N-1:0] req, input int n);
        int idx;
        int res;
        res = ptr;
        // Walk offsets from the far end down so that the smallest offset wins.
        for (int k = MAX_N - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx]) begin
                    res = idx;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry fully registered valid/ready buffer; both ready and data leave from flops.
// Entries are delivered strictly in arrival order from the head register.
module axis_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [W-1:0] s_data_i,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic [W-1:0] m_data_o
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         push;
    logic         pop;

    assign s_ready_o = (count_q != 2'd2);
    assign m_valid_o = (count_q != 2'd0);
    assign m_data_o  = head_q;

    assign push = s_valid_i & s_ready_o;
    assign pop  = m_valid_o & m_ready_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = s_data_i;
                end else begin
                    tail_d = s_data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                end
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the queue just shifts by one entry.
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = s_data_i;
                end else begin
                    head_d = s_data_i;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// N-input AXI-Stream round-robin arbiter that holds each grant for a whole packet.
// The merged stream leaves through a two-entry registered buffer tagged with the source index.
module axis_rr_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int   N_IN   = 5,
    parameter int   DATA_W = 32,
    localparam int  SEL_W  = sel_width(N_IN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_IN*DATA_W-1:0] in_tdata,
    input  logic [N_IN-1:0]        in_tvalid,
    input  logic [N_IN-1:0]        in_tlast,
    output logic [N_IN-1:0]        in_tready,
    output logic [DATA_W-1:0]      out_tdata,
    output logic                   out_tlast,
    output logic [SEL_W-1:0]       out_tid,
    output logic                   out_tvalid,
    input  logic                   out_tready
);

    localparam int SKID_W = DATA_W + 1 + SEL_W;

    arb_state_t        state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  grant_q, grant_d;

    logic [DATA_W-1:0] in_data_arr [N_IN];
    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic              sel_last;
    logic              locked;
    logic              accept;
    logic              skid_ready;
    logic [SKID_W-1:0] skid_in;
    logic [SKID_W-1:0] skid_out;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
            assign in_data_arr[gi] = in_tdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Mux of the granted input, written as a compare loop so any N_IN works.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant_q == SEL_W'(i)) begin
                sel_data  = in_data_arr[i];
                sel_valid = in_tvalid[i];
                sel_last  = in_tlast[i];
            end
        end
    end

    assign locked = (state_q == ARB_LOCKED);
    assign accept = locked & sel_valid & skid_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (|in_tvalid) begin
                    grant_d = SEL_W'(next_rr(int'(ptr_q), MAX_N'(in_tvalid), N_IN));
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                // Only the tlast beat releases the grant; mid-packet stalls keep it.
                if (accept && sel_last) begin
                    state_d = ARB_IDLE;
                    ptr_d   = (grant_q == SEL_W'(N_IN - 1)) ? '0 : grant_q + SEL_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        in_tready = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (locked && (grant_q == SEL_W'(i))) begin
                in_tready[i] = skid_ready;
            end
        end
    end

    assign skid_in = {sel_data, sel_last, grant_q};

    axis_skid_buf #(
        .W (SKID_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid_i (accept),
        .s_ready_o (skid_ready),
        .s_data_i  (skid_in),
        .m_valid_o (out_tvalid),
        .m_ready_i (out_tready),
        .m_data_o  (skid_out)
    );

    assign {out_tdata, out_tlast, out_tid} = skid_out;

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed bench for axis_rr_packet_arbiter with a queue-based scoreboard.
// Sources replay per-input beat lists; a negedge monitor pops expected beats on each output handshake.
module tb_axis_rr_packet_arbiter;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] in_tdata;
    logic [N-1:0]    in_tvalid;
    logic [N-1:0]    in_tlast;
    logic [N-1:0]    in_tready;
    logic [DW-1:0]   out_tdata;
    logic            out_tlast;
    logic [SW-1:0]   out_tid;
    logic            out_tvalid;
    logic            out_tready;

    always #5 clk = ~clk;

    axis_rr_packet_arbiter #(
        .N_IN   (N),
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tlast   (in_tlast),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .out_tid    (out_tid),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic [SW-1:0] id;
        int            c;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            pass_cnt  = 0;
    int            total_cnt = 0;
    int            cyc       = -1;
    int            occ       = 0;
    bit            chk_full  = 1'b0;
    bit            saw_full  = 1'b0;
    logic [3:0]    rdy_pat   = 4'hF;
    logic [N-1:0]  hs_in     = '0;

    logic [DW-1:0] src_data [N][32];
    logic          src_last [N][32];
    int            src_len  [N];
    int            src_idx  [N];
    int            gap_at   [N];
    int            gap_len  [N];
    int            gap_cnt  [N];

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    endtask

    function automatic logic [DW-1:0] mkd(input int s, input int p, input int b);
        return {8'(s), 8'(p), 16'(b)};
    endfunction

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_idx[i] = 0;
            gap_at[i]  = -1;
            gap_len[i] = 0;
            gap_cnt[i] = 0;
        end
    endtask

    task automatic load(input int s, input int p, input int n);
        for (int b = 0; b < n; b++) begin
            src_data[s][src_len[s]] = mkd(s, p, b);
            src_last[s][src_len[s]] = (b == n - 1);
            src_len[s]++;
        end
    endtask

    task automatic expect_beat(input int s, input int p, input int b, input bit l, input int c);
        exp_t e;
        e.d  = mkd(s, p, b);
        e.l  = l;
        e.id = SW'(s);
        e.c  = c;
        exp_q.push_back(e);
    endtask

    // Contiguous beats from cycle c0 onward; c0 < 0 means timing is not checked.
    task automatic expect_pkt(input int s, input int p, input int n, input int c0);
        for (int b = 0; b < n; b++) begin
            expect_beat(s, p, b, b == n - 1, (c0 < 0) ? -1 : c0 + b);
        end
    endtask

    task automatic step();
        logic [N-1:0]    v;
        logic [N-1:0]    l;
        logic [N*DW-1:0] d;
        @(posedge clk);
        #1;
        cyc++;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < N; i++) begin
            if (hs_in[i]) src_idx[i]++;
            if (src_idx[i] < src_len[i]) begin
                if (src_idx[i] == gap_at[i] && gap_cnt[i] < gap_len[i]) begin
                    gap_cnt[i]++;
                end else begin
                    v[i]            = 1'b1;
                    d[i*DW +: DW]   = src_data[i][src_idx[i]];
                    l[i]            = src_last[i][src_idx[i]];
                end
            end
        end
        in_tvalid  = v;
        in_tlast   = l;
        in_tdata   = d;
        out_tready = rdy_pat[cyc % 4];
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) step();
        repeat (3) step();
        chk(exp_q.size() == 0, "drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        clear_src();
        rdy_pat = 4'hF;
        rst_n   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            occ   = 0;
            hs_in = '0;
        end else begin
            chk($countones(in_tready) <= 1, "one_hot_ready", 64'(in_tready), 64'd0);
            if (chk_full && occ == 2) begin
                saw_full = 1'b1;
                chk(in_tready == '0, "ready_when_full", 64'(in_tready), 64'd0);
            end
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", {out_tdata, out_tlast, out_tid}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk({out_tdata, out_tlast, out_tid} == {mon_e.d, mon_e.l, mon_e.id}, "beat",
                        {out_tdata, out_tlast, out_tid}, {mon_e.d, mon_e.l, mon_e.id});
                    if (mon_e.c >= 0) chk(cyc == mon_e.c, "beat_cycle", 64'(cyc), 64'(mon_e.c));
                end
            end
            occ   = occ + $countones(in_tvalid & in_tready) - ((out_tvalid && out_tready) ? 1 : 0);
            hs_in = in_tvalid & in_tready;
        end
    end

    initial begin
        int base;
        rst_n      = 1'b0;
        in_tdata   = '0;
        in_tvalid  = '0;
        in_tlast   = '0;
        out_tready = 1'b0;
        clear_src();
        repeat (3) @(posedge clk);
        #1;
        chk(out_tvalid == 1'b0, "reset_out_tvalid", 64'(out_tvalid), 64'd0);
        chk(in_tready == '0, "reset_in_tready", 64'(in_tready), 64'd0);
        chk({out_tdata, out_tlast, out_tid} == '0, "reset_out_payload", {out_tdata, out_tlast, out_tid}, 64'd0);
        rst_n = 1'b1;

        // Idle: nothing requested, nothing granted.
        for (int k = 0; k < 20; k++) begin
            step();
            chk(out_tvalid == 1'b0 && in_tready == '0, "idle_quiet", {out_tvalid, in_tready}, 64'd0);
        end

        // Inputs 1 and 3 with 4-beat packets, no interleave, one-cycle gap.
        base = cyc + 1;
        load(1, 0, 4);
        load(3, 0, 4);
        expect_pkt(1, 0, 4, base + 2);
        expect_pkt(3, 0, 4, base + 7);
        drain(40);

        // All five inputs stream single-beat packets: 0..4 then wrap to 0.
        do_reset();
        base = cyc + 1;
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < N; s++) begin
                load(s, p, 1);
                expect_beat(s, p, 0, 1'b1, base + 2 + 2 * (p * N + s));
            end
        end
        drain(60);

        // Input 2, 8 beats, downstream ready toggling 1,0,0,1.
        do_reset();
        chk_full = 1'b1;
        rdy_pat  = 4'b1001;
        load(2, 0, 8);
        expect_pkt(2, 0, 8, -1);
        drain(100);
        chk_full = 1'b0;
        rdy_pat  = 4'hF;
        chk(saw_full, "buffer_reached_full", 64'(saw_full), 64'd1);

        // Input 0 stalls 3 cycles mid-packet while input 4 waits.
        do_reset();
        base = cyc + 1;
        load(0, 0, 4);
        gap_at[0]  = 2;
        gap_len[0] = 3;
        load(4, 0, 2);
        expect_beat(0, 0, 0, 1'b0, base + 2);
        expect_beat(0, 0, 1, 1'b0, base + 3);
        expect_beat(0, 0, 2, 1'b0, base + 7);
        expect_beat(0, 0, 3, 1'b1, base + 8);
        expect_beat(4, 0, 0, 1'b0, base + 10);
        expect_beat(4, 0, 1, 1'b1, base + 11);
        drain(40);

        // Move ptr to 3, lock input 4 with a full buffer, then reset mid-packet.
        do_reset();
        load(2, 0, 1);
        expect_beat(2, 0, 0, 1'b1, -1);
        drain(20);
        clear_src();
        rdy_pat = 4'h0;
        load(4, 1, 6);
        repeat (6) step();
        chk(out_tvalid == 1'b1, "pre_reset_valid", 64'(out_tvalid), 64'd1);
        chk(in_tready == '0, "pre_reset_full", 64'(in_tready), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk(out_tvalid == 1'b0, "async_reset_valid", 64'(out_tvalid), 64'd0);
        chk(in_tready == '0, "async_reset_ready", 64'(in_tready), 64'd0);
        clear_src();
        rdy_pat = 4'hF;
        step();
        step();
        rst_n = 1'b1;
        base = cyc + 1;
        load(0, 2, 1);
        load(3, 2, 1);
        expect_beat(0, 2, 0, 1'b1, base + 2);
        expect_beat(3, 2, 0, 1'b1, base + 4);
        drain(30);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/axis_rr_packet_arbiter.md
Name: axis_rr_packet_arbiter

Overview:
Parametrised N-input AXI-Stream round-robin arbiter for the router output ports. It merges N_IN input streams onto one output stream. A grant is locked for a whole packet, from the first accepted beat through the beat carrying tlast. The output is fully registered through a 2-entry skid buffer, so timing is closed on both tready and tdata paths.

Parameters:
N_IN, 5, number of input streams (>=1)
DATA_W, 32, tdata width in bits
SEL_W, ($clog2(N_IN) > 0 ? $clog2(N_IN) : 1), width of source-index field (derived, not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_tdata  input  N_IN*DATA_W  input data; stream i occupies [i*DATA_W +: DATA_W]
in_tvalid  input  N_IN  per-input valid
in_tlast  input  N_IN  per-input end-of-packet
in_tready  output  N_IN  per-input ready
out_tdata  output  DATA_W  merged data
out_tlast  output  1  merged end-of-packet
out_tid  output  SEL_W  index of the input that sourced this beat
out_tvalid  output  1  merged valid
out_tready  input  1  downstream ready

Behaviour:
- Reset values:
  - state=IDLE, ptr=0, grant=0.
  - Skid buffer empty.
  - out_tvalid=0, in_tready=all 0. out_tdata/out_tlast/out_tid=0.
- Arbiter FSM, two states (IDLE, LOCKED):
  - IDLE, no in_tvalid set: stay IDLE.
  - IDLE, any in_tvalid set: grant <= first index i, searching ptr, ptr+1, … mod N_IN, with in_tvalid[i]=1. Go to LOCKED. No beat is transferred in the IDLE cycle.
  - LOCKED: in_tready[grant] = skid_not_full. All other in_tready bits are 0.
  - Beat accepted = in_tvalid[grant] & in_tready[grant]. Each accepted beat is pushed into the skid buffer as {tdata, tlast, grant}.
  - Accepted beat with in_tlast[grant]=1: next state IDLE, ptr <= (grant==N_IN-1) ? 0 : grant+1.
  - Requesters that are not granted are never acknowledged. Their tvalid/tdata must stay stable per AXIS rules.
  - If tvalid of the granted input drops mid-packet, the grant is held and bubbles appear on the output. The grant is never released without tlast.
- Skid buffer (2 entries):
  - skid_not_full = (count != 2).
  - out_tvalid = (count != 0). out_* are driven from head registers.
  - Push and pop in the same cycle leave count unchanged.
  - Pop = out_tvalid & out_tready.
- Timing:
  - Latency: in_tvalid rising in IDLE -> first out_tvalid 2 cycles later (arbitration cycle, then register cycle).
  - Throughput inside a packet: 1 beat/cycle while out_tready=1.
  - Packet-to-packet overhead: 1 idle arbitration cycle.
- Boundary conditions:
  - Single-beat packet (tlast on first beat): LOCKED for exactly 1 accepted beat, then back to IDLE.
  - ptr wrap: grant=N_IN-1 with tlast -> ptr=0.
  - Only the grant holder requesting after its packet: it is re-granted after the IDLE cycle (no starvation, no lock-out).
  - out_tready low: buffer fills to 2, in_tready[grant] drops the next cycle, and no data is lost or duplicated.
  - N_IN=1: degenerates to a registered pass-through with 1 bubble per packet. out_tid=0.
  - rst_n asserted mid-packet: all state is cleared asynchronously and buffered beats are discarded. After release, the arbiter starts from ptr=0 in IDLE.
- Arithmetic: ptr and grant are SEL_W bits; increments are explicit mod N_IN, never a power-of-2 wrap.

Decomposition:
- Package axis_arb_pkg:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t
  - function next_rr(ptr, req, n) returning the first requester index at or after ptr
  - localparam helper for the SEL_W derivation
- Sub-module axis_skid_buf (parameter W): 2-entry registered buffer with s_/m_ valid-ready ports. Instantiated with W = DATA_W+1+SEL_W. Reusable elsewhere in the router.

Test Plan:
- Reset then idle, N_IN=5, all in_tvalid=0 -> out_tvalid=0 and in_tready=0 for 20 cycles; ptr stays 0.
- Inputs 1 and 3 each send a 4-beat packet, both valid at cycle 0, out_tready=1 -> input 1's beats appear on cycles 2–5 with out_tid=1. Input 3's beats appear on cycles 7–10 with out_tid=3 (1-cycle arbitration gap). Packets are never interleaved.
- All 5 inputs continuously send single-beat packets -> out_tid sequence 0,1,2,3,4,0,1,… This checks the wrap from 4 to 0 and fairness.
- Input 2 sends an 8-beat packet with out_tready toggling 1,0,0,1 repeatedly -> all 8 beats arrive in order, in_tready[2] deasserts within 1 cycle of the buffer being full, and no beat is lost or duplicated.
- Input 0 drops tvalid for 3 cycles mid-packet while input 4 is requesting -> grant is held on 0 until its tlast. Input 4 starts only after that.
- Reset asserted while 2 beats are buffered and a packet is locked -> out_tvalid=0 immediately (asynchronous). After release, input 0 requesting alone is granted first.
